// File: rtl/run_detector.sv
// -----------------------------------------------------------------------------
// run_detector
//
// Detects runs of identical WIDTH-bit symbols on a valid-qualified serial
// symbol stream. Once RUN_LEN consecutive equal symbols have been accepted
// the block is in its HIT state; out_bit reports whether that run qualifies
// under the live mode select.
//
// Parameters
//   WIDTH    symbol width in bits (>= 1)
//   RUN_LEN  consecutive equal symbols needed for detection (>= 1)
//   EVT_W    width of the wrapping hit event counter
//   CNT_W    run counter width, derived from RUN_LEN (do not override)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   clear      in   synchronous clear of run state and event counter,
//                   wins over in_valid in the same cycle
//   in_valid   in   in_sym is accepted at this edge
//   in_sym     in   input symbol
//   mode       in   00 any, 01 all-zero only, 10 all-ones only, 11 disabled
//   out_bit    out  qualifying run of >= RUN_LEN in progress (decoded from
//                   registered state and the live mode)
//   hit        out  one-cycle pulse on first qualifying detection of a run
//   run_len    out  length of the current run, saturating at RUN_LEN
//   run_sym    out  symbol of the current run
//   hit_count  out  number of hits since reset/clear, wraps
// -----------------------------------------------------------------------------
module run_detector #(
    parameter int WIDTH   = 1,
    parameter int RUN_LEN = 2,
    parameter int EVT_W   = 8,
    parameter int CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_sym,
    input  logic [1:0]       mode,
    output logic             out_bit,
    output logic             hit,
    output logic [CNT_W-1:0] run_len,
    output logic [WIDTH-1:0] run_sym,
    output logic [EVT_W-1:0] hit_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_SYM  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_SYM  = {WIDTH{1'b1}};
    localparam logic [EVT_W-1:0] EVT_ZERO  = {EVT_W{1'b0}};
    localparam logic [EVT_W-1:0] EVT_ONE   = EVT_W'(1);

    // Does a run of symbol sym count as a detection under mode md?
    function automatic logic qualifies(input logic [WIDTH-1:0] sym,
                                       input logic [1:0]       md);
        logic q;
        case (md)
            2'b00:   q = 1'b1;
            2'b01:   q = (sym == ZERO_SYM);
            2'b10:   q = (sym == ONES_SYM);
            2'b11:   q = 1'b0;
            default: q = 1'b0;
        endcase
        return q;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   sym_q, sym_d;
    logic               hit_q, hit_d;
    logic [EVT_W-1:0]   hit_count_q, hit_count_d;
    logic               same_s;
    logic               start_run_s;

    assign same_s = (in_sym == sym_q);

    // Next-state, run counter, run symbol and hit pulse computation.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sym_d       = sym_q;
        hit_d       = 1'b0;
        start_run_s = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            count_d = ZERO_C;
            sym_d   = ZERO_SYM;
        end else if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    start_run_s = 1'b1;
                end
                ST_RUN: begin
                    if (same_s) begin
                        count_d = count_q + ONE_C;
                        if ((count_q + ONE_C) == RUN_LEN_C) begin
                            state_d = ST_HIT;
                            hit_d   = qualifies(sym_q, mode);
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        start_run_s = 1'b1;
                    end
                end
                ST_HIT: begin
                    // An equal symbol keeps the saturated run; only a new
                    // symbol restarts counting.
                    if (same_s) begin
                        state_d = ST_HIT;
                    end else begin
                        start_run_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = ZERO_C;
                    sym_d   = ZERO_SYM;
                end
            endcase

            // A fresh run is complete immediately when RUN_LEN is 1, so it
            // enters HIT directly and may pulse hit on every new symbol.
            if (start_run_s) begin
                sym_d   = in_sym;
                count_d = ONE_C;
                if (RUN_LEN == 1) begin
                    state_d = ST_HIT;
                    hit_d   = qualifies(in_sym, mode);
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                start_run_s = 1'b0;
            end
        end else begin
            // No accepted symbol: everything holds, hit stays low.
            hit_d = 1'b0;
        end
    end

    // Hit event counter: cleared synchronously, wraps silently.
    always_comb begin
        hit_count_d = hit_count_q;
        if (clear) begin
            hit_count_d = EVT_ZERO;
        end else if (hit_d) begin
            hit_count_d = hit_count_q + EVT_ONE;
        end else begin
            hit_count_d = hit_count_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= ZERO_C;
            sym_q       <= ZERO_SYM;
            hit_q       <= 1'b0;
            hit_count_q <= EVT_ZERO;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sym_q       <= sym_d;
            hit_q       <= hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    // out_bit follows mode without a register stage so a mode change exposes
    // (or hides) an existing run in the same cycle.
    assign out_bit   = (state_q == ST_HIT) && qualifies(sym_q, mode);
    assign hit       = hit_q;
    assign run_len   = count_q;
    assign run_sym   = sym_q;
    assign hit_count = hit_count_q;

endmodule
